// File: rtl/axis_frame_tx.sv
// axis_frame_tx: double-buffered frame serialiser onto an AXI-Stream master port.
// Each frame of N characters is emitted as N beats, TLAST on the final beat.
module axis_frame_tx #(
   parameter int N        = 32,
   parameter int CHAR_LEN = 8,
   parameter int CNT_LEN  = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [N*CHAR_LEN-1:0] d,
   input  logic                  d_valid,
   output logic                  d_ready,
   output logic [CHAR_LEN-1:0]   M_AXIS_TDATA,
   output logic                  M_AXIS_TLAST,
   output logic                  M_AXIS_TVALID,
   input  logic                  M_AXIS_TREADY,
   output logic                  done,
   output logic                  busy,
   output logic [CNT_LEN-1:0]    frame_cnt
);
   localparam int IW = N > 1 ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t state_q, state_d;
   logic [N*CHAR_LEN-1:0] slot_q [2];
   logic [N*CHAR_LEN-1:0] slot_d [2];
   logic wr_q, wr_d, rd_q, rd_d, d_ready_q, d_ready_d, done_q, done_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CNT_LEN-1:0] cnt_q, cnt_d;
   logic [31:0] off;
   logic load, beat, pop;
   assign off           = 32'(idx_q) * 32'(CHAR_LEN);
   assign M_AXIS_TVALID = state_q != EMPTY;
   assign M_AXIS_TLAST  = M_AXIS_TVALID && idx_q == LAST;
   assign M_AXIS_TDATA  = M_AXIS_TVALID ? slot_q[rd_q][off +: CHAR_LEN] : '0;
   assign d_ready       = d_ready_q;
   assign done          = done_q;
   assign busy          = M_AXIS_TVALID;
   assign frame_cnt     = cnt_q;
   assign load          = d_valid & d_ready_q;
   assign beat          = M_AXIS_TVALID & M_AXIS_TREADY;
   assign pop           = beat & M_AXIS_TLAST;
   always_comb begin
      state_d   = state_q == EMPTY ? (load ? ONE : EMPTY)
                : state_q == ONE   ? (load == pop ? ONE : (load ? FULL : EMPTY))
                :                    (pop ? ONE : FULL);
      slot_d[0] = (load && !wr_q) ? d : slot_q[0];
      slot_d[1] = (load &&  wr_q) ? d : slot_q[1];
      wr_d      = wr_q ^ load;
      rd_d      = rd_q ^ pop;
      idx_d     = beat ? (pop ? '0 : idx_q + 1'b1) : idx_q;
      // registered from next state so a pop while FULL only frees the slot next cycle
      d_ready_d = state_d != FULL;
      done_d    = pop;
      cnt_d     = cnt_q + CNT_LEN'(pop);
   end
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= EMPTY;
         slot_q[0] <= '0;
         slot_q[1] <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         idx_q     <= '0;
         d_ready_q <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         slot_q[0] <= slot_d[0];
         slot_q[1] <= slot_d[1];
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         idx_q     <= idx_d;
         d_ready_q <= d_ready_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: tb/tb_axis_frame_tx.sv
// tb_axis_frame_tx: random and directed stimulus against a queue-of-frames model,
// compared on every falling clock edge, plus literal spot checks.
module tb_axis_frame_tx;
   localparam int N  = 32;
   localparam int CL = 8;
   localparam int CW = 2;
   typedef logic [N*CL-1:0] frame_t;
   logic ACLK = 1'b0, ARESETN = 1'b1;
   frame_t d = '0;
   logic d_valid = 1'b0, tready = 1'b0;
   logic d_ready, tlast, tvalid, done, busy;
   logic [CL-1:0] tdata;
   logic [CW-1:0] frame_cnt;
   int checks = 0, failures = 0;
   frame_t mq[$];
   frame_t cf;
   int mb = 0, mcnt = 0;
   bit mdone = 0, mrdy = 0, ld, bt, pp;
   int exp_c[5] = '{1, 2, 3, 0, 1};
   int beats, lasts, dones;

   axis_frame_tx #(.N(N), .CHAR_LEN(CL), .CNT_LEN(CW)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .d(d), .d_valid(d_valid), .d_ready(d_ready),
      .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast), .M_AXIS_TVALID(tvalid),
      .M_AXIS_TREADY(tready), .done(done), .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: frames waiting/in flight as a queue, mb = beat within the head frame
   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         mq.delete();
         mb = 0; mcnt = 0; mdone = 0; mrdy = 0;
      end else begin
         ld = d_valid && mrdy;
         bt = mq.size() > 0 && tready;
         pp = bt && mb == N - 1;
         mdone = pp;
         if (bt) mb++;
         if (pp) begin
            void'(mq.pop_front());
            mb = 0;
            mcnt++;
         end
         if (ld) mq.push_back(d);
         mrdy = mq.size() < 2;
      end
   end

   always @(negedge ACLK) begin
      chk("tvalid", tvalid, mq.size() > 0);
      chk("tlast", tlast, mq.size() > 0 && mb == N - 1);
      chk("busy", busy, mq.size() > 0);
      chk("d_ready", d_ready, mrdy);
      chk("done", done, mdone);
      chk("frame_cnt", frame_cnt, 64'(mcnt % (1 << CW)));
      if (mq.size() > 0) begin
         cf = mq[0];
         chk("tdata", tdata, cf[mb*CL +: CL]);
      end else if (!ARESETN) chk("tdata_rst", tdata, 0);
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   function automatic frame_t mk(input int base);
      frame_t f;
      for (int i = 0; i < N; i++) f[i*CL +: CL] = CL'(base + i);
      return f;
   endfunction

   function automatic frame_t rnd();
      frame_t f;
      for (int i = 0; i < N; i++) f[i*CL +: CL] = CL'($urandom);
      return f;
   endfunction

   task automatic offer(input frame_t f);
      d = f;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      d = rnd();
   endtask

   task automatic drain(input bit rnd_ready, input string name);
      for (int i = 0; i < 3000 && (mq.size() != 0 || busy); i++) begin
         tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
      end
      chk(name, busy, 0);
   endtask

   initial begin
      #2 ARESETN = 1'b0;
      tick();
      chk("rst_d_ready", d_ready, 0);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_cnt", frame_cnt, 0);
      tick();
      ARESETN = 1'b1;
      tick();
      chk("d_ready_after_rst", d_ready, 1);
      // single frame 0x01..0x20
      tready = 1'b1;
      offer(mk(1));
      chk("first_tvalid", tvalid, 1);
      chk("first_tdata", tdata, 8'h01);
      drain(0, "drain_single");
      chk("cnt_single", frame_cnt, 1);
      // backpressure
      offer(mk(8'h41));
      drain(1, "drain_bp");
      chk("cnt_bp", frame_cnt, 2);
      // double buffer
      tready = 1'b0;
      offer(mk(8'hA0));
      offer(mk(8'hB0));
      chk("full_d_ready", d_ready, 0);
      d = mk(8'hC0);
      d_valid = 1'b1;
      repeat (3) tick();
      d_valid = 1'b0;
      chk("third_ignored", d_ready, 0);
      tready = 1'b1;
      beats = 0; lasts = 0; dones = 0;
      for (int i = 0; i < 70; i++) begin
         if (tvalid) beats++;
         if (tvalid && tlast) lasts++;
         if (done) dones++;
         tick();
      end
      chk("dbl_beats", beats, 64);
      chk("dbl_lasts", lasts, 2);
      chk("dbl_dones", dones, 2);
      chk("cnt_dbl", frame_cnt, 0);
      // full + pop collision
      tready = 1'b0;
      offer(mk(8'hA0));
      offer(mk(8'hB0));
      tready = 1'b1;
      repeat (31) tick();
      chk("coll_tlast", tlast, 1);
      d = mk(8'hC0);
      d_valid = 1'b1;
      chk("coll_ready_full", d_ready, 0);
      tick();
      chk("coll_ready_next", d_ready, 1);
      chk("coll_b0", tdata, 8'hB0);
      tick();
      d_valid = 1'b0;
      chk("coll_c_loaded", d_ready, 0);
      drain(0, "drain_coll");
      chk("cnt_coll", frame_cnt, 3);
      // reset mid-frame at beat 10
      tready = 1'b1;
      offer(mk(8'h11));
      repeat (10) tick();
      chk("mid_tdata", tdata, 8'h1B);
      ARESETN = 1'b0;
      #1;
      chk("mid_rst_tvalid", tvalid, 0);
      chk("mid_rst_tlast", tlast, 0);
      chk("mid_rst_tdata", tdata, 0);
      tick();
      tick();
      ARESETN = 1'b1;
      chk("mid_rst_cnt", frame_cnt, 0);
      chk("mid_rst_busy", busy, 0);
      tick();
      // counter wrap across five frames
      for (int k = 0; k < 5; k++) begin
         tready = 1'b1;
         offer(mk(8'h20 + k * 8));
         if (k == 0) chk("post_rst_beat0", tdata, 8'h20);
         drain(0, "drain_wrap");
         chk("cnt_wrap", frame_cnt, exp_c[k]);
      end
      // random traffic
      for (int i = 0; i < 600; i++) begin
         d_valid = $urandom_range(0, 2) == 0;
         d = rnd();
         tready = $urandom_range(0, 3) != 0;
         tick();
      end
      d_valid = 1'b0;
      drain(1, "drain_rand");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axis_frame_tx.md
Name: axis_frame_tx

Overview:
- AXI-Stream transmitter for character frames. It is the counterpart of the frame receiver that collects N characters into an N*CHAR_LEN vector.
- It accepts whole frames from the forward datapath, held in a 2-slot frame buffer, and serialises each frame into N beats of CHAR_LEN bits. TLAST is asserted on the final beat.
- The double buffer lets the forward pipeline hand over frame k+1 while frame k is still draining under backpressure.

Parameters:
- N, 32, characters per frame (matches `N).
- CHAR_LEN, 8, bits per character and TDATA width (matches `CHAR_LEN).
- CNT_LEN, 16, width of the sent-frame counter.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- d  in  N*CHAR_LEN  frame; character i = d[i*CHAR_LEN +: CHAR_LEN].
- d_valid  in  1  frame offered.
- d_ready  out  1  a buffer slot is free; frame taken on d_valid & d_ready.
- M_AXIS_TDATA  out  CHAR_LEN  current character.
- M_AXIS_TLAST  out  1  final beat of a frame.
- M_AXIS_TVALID  out  1  beat available.
- M_AXIS_TREADY  in  1  downstream accepts the beat.
- done  out  1  one-cycle pulse after the final beat of a frame handshakes.
- busy  out  1  at least one frame is buffered or in flight.
- frame_cnt  out  CNT_LEN  frames fully sent since reset.

Behaviour:
- Reset (async, ARESETN=0):
  - Occupancy goes to EMPTY; rd/wr slot pointers go to 0; beat index goes to 0.
  - d_ready is 1 only after release.
  - While in reset: TVALID=0, TLAST=0, TDATA=0, done=0, busy=0, frame_cnt=0.
  - d_ready=0 while ARESETN=0, and 1 from the first cycle after release.
  - Reset mid-frame discards all buffered data immediately; no partial TLAST is emitted.
- Occupancy FSM: EMPTY -> ONE -> FULL.
  - load = d_valid & d_ready; pop = TVALID & TREADY & TLAST.
  - EMPTY: load -> ONE.
  - ONE: load & ~pop -> FULL; pop & ~load -> EMPTY; load & pop -> ONE.
  - FULL: pop -> ONE; no load is possible.
- Outputs derived from occupancy:
  - d_ready = registered (state != FULL). It depends only on state, with no combinational path from TREADY or d_valid.
  - While FULL, a pop in the same cycle does not enable a load; the slot becomes loadable the next cycle.
- Load: d is captured into slot[wr] and wr toggles. Data is not required to be stable after the handshake.
- Output timing:
  - TVALID = (state != EMPTY).
  - TDATA = slot[rd][idx*CHAR_LEN +: CHAR_LEN], selected from registers only.
  - TLAST = TVALID & (idx == N-1).
  - Latency: a frame loaded into EMPTY at edge k presents beat 0 with TVALID=1 in cycle k+1.
- Beat handshake: on TVALID & TREADY, idx increments.
  - At idx==N-1, idx wraps to 0, rd toggles, and the frame is popped.
  - If the other slot is occupied, its beat 0 is presented in the very next cycle, with no bubble between frames.
- AXIS rules:
  - TVALID never deasserts, and TDATA/TLAST never change, while TVALID & ~TREADY.
  - TVALID does not depend combinationally on TREADY.
  - TREADY held low stalls indefinitely with no loss.
- done: registered; 1 in the cycle after each pop, else 0.
- frame_cnt: +1 on each pop; wraps from 2^CNT_LEN-1 to 0.
- busy = (state != EMPTY).
- Ignored inputs: d_valid while d_ready=0 is ignored, and d is never sampled. TREADY while TVALID=0 has no effect.
- N=1 is legal: every beat carries TLAST.

Test Plan:
- Single frame: load d = chars 0x01..0x20 (N=32) with TREADY=1 -> TVALID from the next cycle; 32 consecutive beats 0x01..0x20; TLAST only on 0x20; done pulses once; frame_cnt=1; busy falls the cycle after the last beat.
- Backpressure:
  - Stimulus: same frame, TREADY toggling 1,0,0,1,... (pseudo-random).
  - Required: TDATA/TLAST stable whenever TVALID & ~TREADY; all 32 chars in order; no duplicates.
- Double buffer:
  - Stimulus: load frames A (0xA0..) and B (0xB0..) back-to-back with TREADY=0.
  - Required: d_ready=0 after the second load; a third d_valid is ignored.
  - Release TREADY=1 -> 64 gap-free beats A then B; TLAST on beats 31 and 63; done pulses twice; frame_cnt=2.
- Full + pop collision: in FULL, the final beat of A handshakes while d_valid=1 -> no load that cycle; the load succeeds the following cycle; the C frame follows B intact.
- Reset mid-frame: assert ARESETN=0 at beat 10 of a frame -> TVALID=0 immediately; after release, frame_cnt=0 and busy=0; a new frame transmits from its beat 0 correctly.
- Counter wrap: with CNT_LEN=2, send 5 frames -> frame_cnt sequence 1,2,3,0,1.
